// File: rtl/signed_seq_divider.sv
// signed_seq_divider: iterative signed restoring divider, WIDTH+2 cycles per result.
// Optional macro SIGNED_SEQ_DIV_SAT_EN saturates the overflow and divide-by-zero quotients.
// Rev 1.0
`default_nettype none

module signed_seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] C_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [CW-1:0]    C_CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0]    C_CNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH:0]   r_q;
    logic [WIDTH:0]   r_dvs_mag;
    logic [WIDTH-1:0] r_dvd;
    logic             r_neg_q;
    logic             r_dbz;
    logic             r_ovf;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;
    logic             r_ovf_out;

    logic [WIDTH:0]   w_dvd_ext;
    logic [WIDTH:0]   w_dvs_ext;
    logic [WIDTH:0]   w_dvd_mag;
    logic [WIDTH:0]   w_dvs_mag;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH+1:0] w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic             w_dvs_zero;

    // Sign-extend to WIDTH+1 bits so the magnitude of the most-negative value fits.
    assign w_dvd_ext  = {dividend[WIDTH-1], dividend};
    assign w_dvs_ext  = {divisor[WIDTH-1], divisor};
    assign w_dvd_mag  = dividend[WIDTH-1] ? -w_dvd_ext : w_dvd_ext;
    assign w_dvs_mag  = divisor[WIDTH-1]  ? -w_dvs_ext : w_dvs_ext;
    assign w_dvs_zero = (divisor == '0);

    assign w_rem_sh = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_trial  = {1'b0, w_rem_sh} - {1'b0, r_dvs_mag};
    assign w_ge     = ~w_trial[WIDTH+1];

    assign w_q_fix  = WIDTH'(r_neg_q ? -r_q : r_q);
    assign w_r_fix  = WIDTH'(r_dvd[WIDTH-1] ? -r_rem : r_rem);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_dvs_zero ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_rem         <= '0;
            r_q           <= '0;
            r_dvs_mag     <= '0;
            r_dvd         <= '0;
            r_neg_q       <= 1'b0;
            r_dbz         <= 1'b0;
            r_ovf         <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_ovf_out     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt     <= C_CNT_LOAD;
                        r_rem     <= '0;
                        r_q       <= w_dvd_mag;
                        r_dvs_mag <= w_dvs_mag;
                        r_dvd     <= dividend;
                        r_neg_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_dbz     <= w_dvs_zero;
                        r_ovf     <= (dividend == C_MIN) && (divisor == '1);
                        r_busy    <= 1'b1;
                    end
                end
                S_CALC: begin
                    // Top quotient bit is cleared as it moves into the remainder.
                    r_q   <= {1'b0, r_q[WIDTH-2:0], w_ge};
                    r_rem <= w_ge ? w_trial[WIDTH:0] : w_rem_sh;
                    r_cnt <= r_cnt - C_CNT_LAST;
                end
                S_FIX: begin
`ifdef SIGNED_SEQ_DIV_SAT_EN
                    if (r_dbz) begin
                        r_quotient <= r_dvd[WIDTH-1] ? C_MIN : C_MAX;
                    end else if (r_ovf) begin
                        r_quotient <= C_MAX;
                    end else begin
                        r_quotient <= w_q_fix;
                    end
`else
                    r_quotient <= r_dbz ? '1 : w_q_fix;
`endif
                    r_remainder   <= r_dbz ? r_dvd : w_r_fix;
                    r_div_by_zero <= r_dbz;
                    r_ovf_out     <= r_ovf;
                    r_done        <= 1'b1;
                    r_busy        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;
    assign ovf         = r_ovf_out;

endmodule

`default_nettype wire

// File: tb/tb_signed_seq_divider.sv
// tb_signed_seq_divider: directed self-checking bench for signed_seq_divider (WIDTH=8).
// Rev 1.0
`default_nettype none

module tb_signed_seq_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;
    logic       ovf;

    int errs   = 0;
    int checks = 0;

    signed_seq_divider #(.WIDTH(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_q"},    quotient, 0);
        chk({tag, "_r"},    remainder, 0);
        chk({tag, "_dbz"},  div_by_zero, 0);
        chk({tag, "_ovf"},  ovf, 0);
    endtask

    // Waits (bounded) for done; n counts edges starting from the accept edge as 1.
    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er,
                          input logic edz, input logic eov, input int elat);
        int n;
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_acc"}, busy, 1);
        wait_done(n);
        chk({tag, "_lat"},  n, elat);
        chk({tag, "_q"},    quotient, eq);
        chk({tag, "_r"},    remainder, er);
        chk({tag, "_dbz"},  div_by_zero, edz);
        chk({tag, "_ovf"},  ovf, eov);
        chk({tag, "_busy_done"}, busy, 0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_q_hold"}, quotient, eq);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int extra;
        logic [7:0] q_ovf, q_dz_pos, q_dz_neg;
`ifdef SIGNED_SEQ_DIV_SAT_EN
        q_ovf = 8'h7F; q_dz_pos = 8'h7F; q_dz_neg = 8'h80;
`else
        q_ovf = 8'h80; q_dz_pos = 8'hFF; q_dz_neg = 8'hFF;
`endif
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        do_div("p100_7",   8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0, 10);
        do_div("n100_7",   8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0, 10);
        do_div("p100_n7",  8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0, 10);
        do_div("n100_n7",  8'h9C,  8'hF9,  8'h0E, 8'hFE, 1'b0, 1'b0, 10);
        do_div("min_n1",   8'h80,  8'hFF,  q_ovf, 8'h00, 1'b0, 1'b1, 10);
        do_div("min_1",    8'h80,  8'h01,  8'h80, 8'h00, 1'b0, 1'b0, 10);
        do_div("p127_min", 8'h7F,  8'h80,  8'h00, 8'h7F, 1'b0, 1'b0, 10);
        do_div("min_min",  8'h80,  8'h80,  8'h01, 8'h00, 1'b0, 1'b0, 10);
        do_div("p5_0",     8'd5,   8'd0,   q_dz_pos, 8'h05, 1'b1, 1'b0, 2);
        do_div("n5_0",     8'hFB,  8'd0,   q_dz_neg, 8'hFB, 1'b1, 1'b0, 2);

        // Start while busy must be ignored.
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        dividend = 8'd50; divisor = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 4;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ign_lat", n, 10);
        chk("ign_q", quotient, 8'h0E);
        chk("ign_r", remainder, 8'h02);
        extra = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        chk("ign_extra_done", extra, 0);
        chk("ign_busy", busy, 0);

        // Start held high through the done cycle starts a second division.
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        wait_done(n);
        chk("held1_lat", n, 10);
        chk("held1_q", quotient, 8'h0E);
        chk("held1_r", remainder, 8'h02);
        dividend = 8'd50; divisor = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        chk("held2_busy", busy, 1);
        chk("held2_done_low", done, 0);
        wait_done(n);
        chk("held2_lat", n, 10);
        chk("held2_q", quotient, 8'h0A);
        chk("held2_r", remainder, 8'h00);

        // Reset mid-operation at N+4 aborts without a done pulse.
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        extra = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_no_done", extra, 0);
        chk_outputs_zero("rstmid");
        rst_n = 1'b1;
        do_div("after_rst", 8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 1'b0, 10);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire
